// File: rtl/im_stage_pkg.sv
// im_stage_pkg: shared size encodings, FSM states and counter sizing for the memory stage
package im_stage_pkg;
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   function automatic int cnt_width(input int timeout);
      return (timeout <= 1) ? 1 : $clog2(timeout + 1);
   endfunction
endpackage

// File: rtl/im_stage_lsu_align.sv
// im_stage_lsu_align: store byte-lane placement, load extraction/extension and misalignment check
module im_stage_lsu_align
   import im_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       size,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] st_data,
   input  logic [WIDTH-1:0] rdata,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] ld_data,
   output logic             misaligned
);
   logic       is_b;
   logic       is_h;
   logic [7:0] rd_byte;
   logic [15:0] rd_half;

   // lane steering in both directions; BU/HU share the alignment rules of B/H
   always_comb begin
      is_b       = (size == SZ_B) || (size == SZ_BU);
      is_h       = (size == SZ_H) || (size == SZ_HU);
      misaligned = is_h ? addr[0] : (is_b ? 1'b0 : |addr);
      be         = is_b ? 4'b0001 << addr : (is_h ? 4'b0011 << {addr[1], 1'b0} : 4'b1111);
      wdata      = is_b ? {(WIDTH/8){st_data[7:0]}} : (is_h ? {(WIDTH/16){st_data[15:0]}} : st_data);
      rd_byte    = 8'(rdata >> {addr, 3'b000});
      rd_half    = 16'(rdata >> {addr[1], 4'b0000});
      ld_data    = (size == SZ_B)  ? {{(WIDTH-8){rd_byte[7]}}, rd_byte} :
                   (size == SZ_BU) ? {{(WIDTH-8){1'b0}}, rd_byte} :
                   (size == SZ_H)  ? {{(WIDTH-16){rd_half[15]}}, rd_half} :
                   (size == SZ_HU) ? {{(WIDTH-16){1'b0}}, rd_half} : rdata;
   end
endmodule

// File: rtl/im_stage.sv
// im_stage: memory-access stage; drives the data bus, stalls while waiting, fills the MEM/WB register
module im_stage
   import im_stage_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int I_ADD_SIZE  = 32,
   parameter int RF_ADD_SIZE = 5,
   parameter int TIMEOUT     = 255
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic [WIDTH-1:0]       i_im_alu_out,
   input  logic [WIDTH-1:0]       i_im_write_data,
   input  logic                   i_im_mem_we,
   input  logic                   i_im_mem_re,
   input  logic [2:0]             i_im_mem_size,
   input  logic                   i_im_rf_we_ctrl,
   input  logic [2:0]             i_im_rf_wb_src_ctrl,
   input  logic [WIDTH-1:0]       i_im_sx_data,
   input  logic [I_ADD_SIZE-1:0]  i_im_pc_plus_4,
   input  logic [WIDTH-1:0]       i_im_bu_next_dest_jb,
   input  logic [RF_ADD_SIZE-1:0] i_im_dst,
   output logic [WIDTH-1:0]       o_m_alu_out,
   output logic                   o_im_stall,
   output logic                   o_dmem_req,
   output logic                   o_dmem_we,
   output logic [WIDTH-1:0]       o_dmem_addr,
   output logic [WIDTH-1:0]       o_dmem_wdata,
   output logic [3:0]             o_dmem_be,
   input  logic                   i_dmem_ack,
   input  logic [WIDTH-1:0]       i_dmem_rdata,
   output logic [WIDTH-1:0]       o_iwb_alu_out,
   output logic [WIDTH-1:0]       o_iwb_load_data,
   output logic [WIDTH-1:0]       o_iwb_sx_data,
   output logic [WIDTH-1:0]       o_iwb_bu_next_dest_jb,
   output logic [I_ADD_SIZE-1:0]  o_iwb_pc_plus_4,
   output logic                   o_iwb_rf_we_ctrl,
   output logic [2:0]             o_iwb_rf_wb_src_ctrl,
   output logic [RF_ADD_SIZE-1:0] o_iwb_dst,
   output logic                   o_iwb_misaligned,
   output logic                   o_iwb_bus_err
);
   localparam int             CW     = cnt_width(TIMEOUT);
   localparam logic [CW-1:0]  T_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            mem_op, is_load, mis, mis_op, hit, abort, ld_done;
   logic [3:0]      st_be;
   logic [WIDTH-1:0] st_wdata, ld_ext;

   im_stage_lsu_align #(.WIDTH(WIDTH)) u_align (
      .size       (i_im_mem_size),
      .addr       (i_im_alu_out[1:0]),
      .st_data    (i_im_write_data),
      .rdata      (i_dmem_rdata),
      .be         (st_be),
      .wdata      (st_wdata),
      .ld_data    (ld_ext),
      .misaligned (mis)
   );

   assign mem_op       = i_im_mem_we | i_im_mem_re;
   assign is_load      = i_im_mem_re & ~i_im_mem_we;
   assign mis_op       = mem_op & mis;
   assign o_m_alu_out  = i_im_alu_out;
   assign o_dmem_addr  = {i_im_alu_out[WIDTH-1:2], 2'b00};
   assign o_dmem_we    = o_dmem_req & i_im_mem_we;
   assign o_dmem_be    = i_im_mem_we ? st_be : 4'b1111;
   assign o_dmem_wdata = st_wdata;

   // state and WAIT-cycle counter; reset abandons any outstanding access
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // request/timeout decode; ack wins over a timeout landing in the same cycle
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      o_dmem_req = 1'b0;
      hit        = 1'b0;
      if (state == ST_IDLE) begin
         o_dmem_req = i_rstn & mem_op & ~mis;
         state_n    = (o_dmem_req & ~i_dmem_ack) ? ST_WAIT : ST_IDLE;
         cnt_n      = '0;
      end else begin
         o_dmem_req = i_rstn;
         hit        = (TIMEOUT != 0) && (cnt == T_LAST);
         state_n    = (i_dmem_ack | hit) ? ST_IDLE : ST_WAIT;
         cnt_n      = (&cnt) ? cnt : cnt + CW'(1);
      end
      abort      = hit & ~i_dmem_ack;
      ld_done    = is_load & o_dmem_req & i_dmem_ack;
      o_im_stall = o_dmem_req & ~i_dmem_ack & ~hit;
   end

   // MEM/WB register: bubbles while stalled so each instruction retires once
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_iwb_alu_out         <= '0;
         o_iwb_load_data       <= '0;
         o_iwb_sx_data         <= '0;
         o_iwb_bu_next_dest_jb <= '0;
         o_iwb_pc_plus_4       <= '0;
         o_iwb_rf_we_ctrl      <= 1'b0;
         o_iwb_rf_wb_src_ctrl  <= '0;
         o_iwb_dst             <= '0;
         o_iwb_misaligned      <= 1'b0;
         o_iwb_bus_err         <= 1'b0;
      end else begin
         o_iwb_alu_out         <= o_im_stall ? '0 : i_im_alu_out;
         o_iwb_load_data       <= ld_done ? ld_ext : '0;
         o_iwb_sx_data         <= o_im_stall ? '0 : i_im_sx_data;
         o_iwb_bu_next_dest_jb <= o_im_stall ? '0 : i_im_bu_next_dest_jb;
         o_iwb_pc_plus_4       <= o_im_stall ? '0 : i_im_pc_plus_4;
         o_iwb_rf_we_ctrl      <= ~o_im_stall & i_im_rf_we_ctrl & ~mis_op & ~abort;
         o_iwb_rf_wb_src_ctrl  <= o_im_stall ? '0 : i_im_rf_wb_src_ctrl;
         o_iwb_dst             <= o_im_stall ? '0 : i_im_dst;
         o_iwb_misaligned      <= mis_op;
         o_iwb_bus_err         <= abort;
      end
   end
endmodule

// File: tb/tb_im_stage.sv
// tb_im_stage: directed vectors with hand-computed expectations for the memory stage
module tb_im_stage;
   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic [31:0] alu, wd, sx, bu, rdata;
   logic        we, re, rfwe, ack;
   logic [2:0]  sz, wbsrc;
   logic [31:0] pc4;
   logic [4:0]  dst;
   logic [31:0] m_alu, d_addr, d_wdata, w_alu, w_ld, w_sx, w_bu, w_pc4;
   logic        stall, req, d_we, w_rfwe, w_mis, w_err;
   logic [3:0]  d_be;
   logic [2:0]  w_src;
   logic [4:0]  w_dst;
   int          n_chk = 0;
   int          n_fail = 0;

   im_stage #(.WIDTH(32), .I_ADD_SIZE(32), .RF_ADD_SIZE(5), .TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_im_alu_out(alu), .i_im_write_data(wd), .i_im_mem_we(we), .i_im_mem_re(re),
      .i_im_mem_size(sz), .i_im_rf_we_ctrl(rfwe), .i_im_rf_wb_src_ctrl(wbsrc),
      .i_im_sx_data(sx), .i_im_pc_plus_4(pc4), .i_im_bu_next_dest_jb(bu), .i_im_dst(dst),
      .o_m_alu_out(m_alu), .o_im_stall(stall), .o_dmem_req(req), .o_dmem_we(d_we),
      .o_dmem_addr(d_addr), .o_dmem_wdata(d_wdata), .o_dmem_be(d_be),
      .i_dmem_ack(ack), .i_dmem_rdata(rdata),
      .o_iwb_alu_out(w_alu), .o_iwb_load_data(w_ld), .o_iwb_sx_data(w_sx),
      .o_iwb_bu_next_dest_jb(w_bu), .o_iwb_pc_plus_4(w_pc4), .o_iwb_rf_we_ctrl(w_rfwe),
      .o_iwb_rf_wb_src_ctrl(w_src), .o_iwb_dst(w_dst), .o_iwb_misaligned(w_mis),
      .o_iwb_bus_err(w_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drv(input logic w, input logic r, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rd, input logic k,
                      input logic f, input logic [4:0] ds);
      we = w; re = r; sz = s; alu = a; wd = d; rdata = rd; ack = k; rfwe = f; dst = ds;
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rstn = 1'b0;
      sx = 32'h55; pc4 = 32'h1000; bu = 32'h2000; wbsrc = 3'b001;
      drv(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0);
      #12;
      chk("rst_rfwe", w_rfwe, 0);
      chk("rst_alu", w_alu, 0);
      chk("rst_req", req, 0);
      chk("rst_stall", stall, 0);

      // SW, immediate ack
      drv(1, 0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1, 0, 5'd0);
      i_rstn = 1'b1;
      @(negedge i_clk);
      chk("sw_req", req, 1);
      chk("sw_we", d_we, 1);
      chk("sw_be", d_be, 4'b1111);
      chk("sw_addr", d_addr, 32'h104);
      chk("sw_wdata", d_wdata, 32'hDEADBEEF);
      chk("sw_stall", stall, 0);
      chk("sw_fwd", m_alu, 32'h104);
      tick;
      chk("sw_rfwe", w_rfwe, 0);
      chk("sw_mis", w_mis, 0);

      // SB lane replication
      drv(1, 0, 3'b000, 32'h102, 32'h000000A5, 32'h0, 1, 0, 5'd0);
      @(negedge i_clk);
      chk("sb_be", d_be, 4'b0100);
      chk("sb_wdata", d_wdata, 32'hA5A5A5A5);
      chk("sb_addr", d_addr, 32'h100);
      tick;

      // SH lane replication, upper half
      drv(1, 0, 3'b001, 32'h102, 32'h0000CAFE, 32'h0, 1, 0, 5'd0);
      @(negedge i_clk);
      chk("sh_be", d_be, 4'b1100);
      chk("sh_wdata", d_wdata, 32'hCAFECAFE);
      tick;

      // LB with ack after 3 stalled cycles
      drv(0, 1, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 0, 1, 5'd7);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("lb_stall", stall, 1);
         chk("lb_req", req, 1);
         chk("lb_we", d_we, 0);
         tick;
         chk("lb_bub_rfwe", w_rfwe, 0);
         chk("lb_bub_dst", w_dst, 0);
      end
      ack = 1'b1;
      @(negedge i_clk);
      chk("lb_ack_stall", stall, 0);
      tick;
      chk("lb_rfwe", w_rfwe, 1);
      chk("lb_dst", w_dst, 7);
      chk("lb_data", w_ld, 32'hFFFFFF80);
      drv(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0);
      tick;
      chk("lb_once", w_rfwe, 0);
      chk("nonload_data", w_ld, 0);

      // LHU / LH at upper half
      drv(0, 1, 3'b101, 32'h202, 32'h0, 32'hBEEF1234, 1, 1, 5'd4);
      @(negedge i_clk);
      chk("lhu_be", d_be, 4'b1111);
      chk("lhu_stall", stall, 0);
      tick;
      chk("lhu_data", w_ld, 32'h0000BEEF);
      chk("lhu_rfwe", w_rfwe, 1);
      drv(0, 1, 3'b001, 32'h202, 32'h0, 32'hBEEF1234, 1, 1, 5'd4);
      tick;
      chk("lh_data", w_ld, 32'hFFFFBEEF);
      drv(0, 1, 3'b100, 32'h201, 32'h0, 32'h0000F100, 1, 1, 5'd4);
      tick;
      chk("lbu_data", w_ld, 32'h000000F1);

      // misaligned SH
      drv(1, 0, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 1, 5'd2);
      @(negedge i_clk);
      chk("mis_req", req, 0);
      chk("mis_stall", stall, 0);
      tick;
      chk("mis_flag", w_mis, 1);
      chk("mis_rfwe", w_rfwe, 0);
      drv(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0);
      tick;
      chk("mis_single", w_mis, 0);

      // LW timeout (TIMEOUT=4)
      drv(0, 1, 3'b010, 32'h300, 32'h0, 32'h0, 0, 1, 5'd5);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("to_stall", stall, 1);
         tick;
      end
      @(negedge i_clk);
      chk("to_hit_stall", stall, 0);
      tick;
      chk("to_err", w_err, 1);
      chk("to_rfwe", w_rfwe, 0);
      drv(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0);
      @(negedge i_clk);
      chk("to_req_drop", req, 0);
      tick;
      chk("to_err_single", w_err, 0);

      // reset in WAIT
      drv(0, 1, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1, 5'd6);
      tick;
      tick;
      chk("rw_req_pre", req, 1);
      #2 i_rstn = 1'b0;
      #1;
      chk("rw_req", req, 0);
      chk("rw_stall", stall, 0);
      chk("rw_rfwe", w_rfwe, 0);
      chk("rw_dst", w_dst, 0);
      drv(0, 0, 3'b010, 32'h1234, 32'h0, 32'h0, 0, 1, 5'd9);
      tick;
      chk("rw_hold", w_alu, 0);
      i_rstn = 1'b1;
      @(negedge i_clk);
      chk("rw_idle_req", req, 0);
      tick;
      chk("pass_alu", w_alu, 32'h1234);
      chk("pass_rfwe", w_rfwe, 1);
      chk("pass_dst", w_dst, 9);
      chk("pass_pc4", w_pc4, 32'h1000);
      chk("pass_sx", w_sx, 32'h55);
      chk("pass_bu", w_bu, 32'h2000);
      chk("pass_src", w_src, 3'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/im_stage.md
Name: im_stage

Overview:
- Memory-access stage of the pipelined RV32I core, directly downstream of the execute stage.
- Consumes the execute/memory pipeline register and drives a req/ack data-memory bus. Performs byte-lane alignment for stores and sign/zero extension for loads.
- Stalls the pipeline while an access is outstanding and enforces a bus timeout.
- Registers all results into the memory/write-back pipeline register, and exports the combinational ALU-result forward path.

Parameters:
- WIDTH, `WIDTH (32): datapath width.
- I_ADD_SIZE, `I_ADD_SIZE: instruction-address width.
- RF_ADD_SIZE, `RF_ADD_SIZE (5): register-file address width.
- TIMEOUT, 255: maximum WAIT cycles before an access aborts. 0 disables the timeout.

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_im_alu_out  in  WIDTH  ALU result; memory byte address
i_im_write_data  in  WIDTH  store data, already forwarded
i_im_mem_we  in  1  store request
i_im_mem_re  in  1  load request
i_im_mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_im_rf_we_ctrl  in  1  register-file write enable
i_im_rf_wb_src_ctrl  in  3  write-back source select
i_im_sx_data  in  WIDTH  sign-extended immediate
i_im_pc_plus_4  in  I_ADD_SIZE  PC+4
i_im_bu_next_dest_jb  in  WIDTH  branch/jump target
i_im_dst  in  RF_ADD_SIZE  destination register
o_m_alu_out  out  WIDTH  forward path, equal to i_im_alu_out (combinational)
o_im_stall  out  1  hold all upstream stages (combinational)
o_dmem_req  out  1  bus request
o_dmem_we  out  1  bus write
o_dmem_addr  out  WIDTH  word-aligned address, {alu_out[WIDTH-1:2],2'b00}
o_dmem_wdata  out  WIDTH  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  access complete; rdata valid in the same cycle
i_dmem_rdata  in  WIDTH  read word
o_iwb_alu_out, o_iwb_load_data, o_iwb_sx_data, o_iwb_bu_next_dest_jb  out  WIDTH  write-back register fields
o_iwb_pc_plus_4  out  I_ADD_SIZE  write-back register field
o_iwb_rf_we_ctrl  out  1  write-back register field
o_iwb_rf_wb_src_ctrl  out  3  write-back register field
o_iwb_dst  out  RF_ADD_SIZE  write-back register field
o_iwb_misaligned  out  1  registered exception flag
o_iwb_bus_err  out  1  registered exception flag

Behaviour:
- Reset (async, i_rstn=0):
  - All o_iwb_* are 0 and the FSM is in IDLE.
  - Timeout counter is 0; o_dmem_req and o_im_stall drop immediately.
  - Reset during WAIT abandons the access; no write-back occurs.
- Definitions:
  - mem_op = i_im_mem_we | i_im_mem_re. If both are set, the operation is a store.
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Unlisted size codes behave as W.
- FSM states: IDLE, WAIT.
  - IDLE, mem_op & aligned: assert o_dmem_req in the same cycle. If i_dmem_ack, complete this cycle; otherwise go to WAIT.
  - WAIT: hold o_dmem_req and all bus outputs. On ack, complete and return to IDLE. When the counter reaches TIMEOUT (TIMEOUT>0), abort and return to IDLE.
  - Counter clears on entry to WAIT and increments each WAIT cycle; it saturates when TIMEOUT=0.
- Stall: o_im_stall = o_dmem_req & ~i_dmem_ack & ~timeout_hit. Upstream holds i_im_* stable while o_im_stall=1.
- Write-back register update, every clock edge:
  - While o_im_stall=1: load a bubble (rf_we_ctrl=0, dst=0, flags=0) so the instruction retires exactly once.
  - Otherwise: capture the i_im_* fields and the extended load data.
  - Misaligned: no bus request; capture with rf_we_ctrl=0 and o_iwb_misaligned=1 (single cycle).
  - Timeout abort: capture with rf_we_ctrl=0 and o_iwb_bus_err=1.
  - Non-memory instructions pass through with 1-cycle latency.
- Store lanes:
  - B: be = 0001<<addr[1:0], wdata = byte replicated x4.
  - H: be = 0011<<{addr[1],1'b0}, wdata = half replicated x2.
  - W: be = 1111.
  - Loads drive be = 1111 and o_dmem_we = 0.
- Load extraction: select the byte/half at addr[1:0] from rdata. B and H sign-extend; BU and HU zero-extend. o_iwb_load_data = 0 for non-loads.

Decomposition:
- Shared constants in parameters.vh:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU;
  - FSM state encodings ST_IDLE/ST_WAIT;
  - counter width derived from TIMEOUT (clog2, minimum 1).
- One combinational sub-module, lsu_align: inputs are size, addr[1:0], store data and rdata; outputs are be, wdata, extended load data and the misaligned flag.

Test Plan:
- SW addr=0x104, data=0xDEADBEEF, ack in the same cycle:
  - bus: req=1, we=1, be=1111, addr=0x104;
  - stall=0; next cycle o_iwb_rf_we_ctrl=0.
- LB addr=0x203, rdata=0x80FF_7F01, ack after 3 cycles:
  - stall high exactly 3 cycles, with bubbles in the write-back register;
  - then load_data=0xFFFFFF80, retired once.
- LHU addr=0x202, rdata=0xBEEF_1234, immediate ack -> load_data=0x0000BEEF.
- SH addr=0x101 -> no req; next cycle misaligned=1 and rf_we_ctrl=0.
- TIMEOUT=4, LW with ack never asserted:
  - stall for 4 cycles, then req drops;
  - bus_err=1 for one cycle, rf_we_ctrl=0.
- Assert i_rstn=0 mid-WAIT:
  - req, stall and all o_iwb_* go to 0 asynchronously;
  - after release, a non-memory instruction passes with 1-cycle latency.
